// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and default widths for the instruction-fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/instr_fetch_seq_dwell_timer.sv
// dwell_timer: counts 0..DWELL-1 while enabled; tick marks the last (issue) cycle.
// Ports: clk, rst_n (sync, active-low), enable (advance), clear (restart at 0), tick (issue cycle).
module dwell_timer
    import fetch_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = DWELL > 1 ? $clog2(DWELL) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == W'(DWELL - 1));

    always_comb cnt_d = clear ? '0 : tick ? '0 : enable ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: steps the instruction-memory word address with a programmable dwell per
// instruction, issuing one strobe per instruction, with stall, branch, halt and count limit.
// Ports: clk, rst_n (sync, active-low); start/start_addr begin fetching; stall freezes;
// branch_valid/branch_target redirect on the issue cycle; halt_req stops; mem_data is the
// memory read of word_address; instr/instr_valid go to decode; busy (RUN), done (DONE);
// issued_cnt counts issues since start (saturating).
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DWELL     = 4,
    parameter int MAX_INSTR = 31,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] word_address,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_cnt
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load, run_en, issue;

    // start is honoured only outside RUN; halt and stall both freeze the dwell timer
    assign load   = start && (state_q != RUN);
    assign run_en = (state_q == RUN) && !halt_req && !stall;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (run_en),
        .clear  (load),
        .tick   (issue)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = RUN;
            addr_d  = start_addr;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (halt_req) begin
                state_d = DONE;
            end else if (issue) begin
                instr_d = mem_data;
                valid_d = 1'b1;
                cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                addr_d  = branch_valid ? branch_target : addr_q + ADDR_W'(1);
                if (cnt_d == CNT_W'(MAX_INSTR)) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_address = addr_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign issued_cnt   = cnt_q;
    assign busy         = state_q == RUN;
    assign done         = state_q == DONE;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed checks of the fetch sequencer with DWELL=4/MAX=31 and DWELL=1/MAX=4.
module tb_instr_fetch_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, stall = 1'b0, branch_valid = 1'b0, halt_req = 1'b0;
    logic [4:0]  start_addr = '0, branch_target = '0;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] mem_a, mem_b, instr_a, instr_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] cnt_a, cnt_b;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [4:0] a);
        return {a, 11'h5A5, 8'h3C, ~a, 3'b101};
    endfunction

    assign mem_a = mem(addr_a);
    assign mem_b = mem(addr_b);

    instr_fetch_seq #(.ADDR_W(5), .DATA_W(32), .DWELL(4), .MAX_INSTR(31), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .start_addr(start_addr), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target), .halt_req(halt_req),
        .mem_data(mem_a), .word_address(addr_a), .instr(instr_a), .instr_valid(valid_a),
        .busy(busy_a), .done(done_a), .issued_cnt(cnt_a)
    );

    instr_fetch_seq #(.ADDR_W(5), .DATA_W(32), .DWELL(1), .MAX_INSTR(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .start_addr(start_addr), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target), .halt_req(halt_req),
        .mem_data(mem_b), .word_address(addr_b), .instr(instr_b), .instr_valid(valid_b),
        .busy(busy_b), .done(done_b), .issued_cnt(cnt_b)
    );

    task automatic wait_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < 40);
    endtask

    task automatic pulse_start_a(input logic [4:0] a);
        start_addr = a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({addr_a, instr_a, valid_a, busy_a, done_a, cnt_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: addr=%0d instr=%h valid=%b busy=%b done=%b cnt=%0d, want all 0",
                     addr_a, instr_a, valid_a, busy_a, done_a, cnt_a);
        end
        checks++;
        if ({addr_b, instr_b, valid_b, busy_b, done_b, cnt_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: addr=%0d instr=%h valid=%b busy=%b done=%b cnt=%0d, want all 0",
                     addr_b, instr_b, valid_b, busy_b, done_b, cnt_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequential;
        int n;
        pulse_start_a(5'd0);
        checks++;
        if (busy_a !== 1'b1 || addr_a !== 5'd0) begin
            errors++;
            $display("FAIL seq_start: busy=%b addr=%0d, want busy=1 addr=0", busy_a, addr_a);
        end
        for (int i = 0; i < 31; i++) begin
            wait_a(n);
            checks++;
            if (n !== 4 || instr_a !== mem(5'(i)) || cnt_a !== 16'(i + 1)) begin
                errors++;
                $display("FAIL seq_issue%0d: gap=%0d instr=%h cnt=%0d, want gap=4 instr=%h cnt=%0d",
                         i, n, instr_a, cnt_a, mem(5'(i)), i + 1);
            end
        end
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 16'd31 || addr_a !== 5'd31) begin
            errors++;
            $display("FAIL seq_done: done=%b busy=%b cnt=%0d addr=%0d, want done=1 busy=0 cnt=31 addr=31",
                     done_a, busy_a, cnt_a, addr_a);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b1 || cnt_a !== 16'd31 || instr_a !== mem(5'd30)) begin
            errors++;
            $display("FAIL seq_hold: valid=%b done=%b cnt=%0d instr=%h, want valid=0 done=1 cnt=31 instr=%h",
                     valid_a, done_a, cnt_a, instr_a, mem(5'd30));
        end
    endtask

    task automatic test_wrap;
        logic [4:0] e;
        start_addr = 5'd30;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = 5'(30 + i);
            checks++;
            if (valid_b !== 1'b1 || instr_b !== mem(e) || cnt_b !== 16'(i + 1)) begin
                errors++;
                $display("FAIL wrap_issue%0d: valid=%b instr=%h cnt=%0d, want valid=1 instr=%h cnt=%0d",
                         i, valid_b, instr_b, cnt_b, mem(e), i + 1);
            end
        end
        checks++;
        if (done_b !== 1'b1 || addr_b !== 5'd2) begin
            errors++;
            $display("FAIL wrap_done: done=%b addr=%0d, want done=1 addr=2", done_b, addr_b);
        end
        @(negedge clk);
        checks++;
        if (valid_b !== 1'b0 || cnt_b !== 16'd4) begin
            errors++;
            $display("FAIL wrap_hold: valid=%b cnt=%0d, want valid=0 cnt=4", valid_b, cnt_b);
        end
    endtask

    task automatic test_stall;
        int n;
        logic bad;
        pulse_start_a(5'd0);
        for (int i = 0; i < 3; i++) begin
            wait_a(n);
            checks++;
            if (instr_a !== mem(5'(i)) || n !== 4) begin
                errors++;
                $display("FAIL stall_pre%0d: instr=%h gap=%0d, want instr=%h gap=4", i, instr_a, n, mem(5'(i)));
            end
        end
        repeat (3) @(negedge clk);
        stall = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || cnt_a !== 16'd3 || addr_a !== 5'd3) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: valid=%b cnt=%0d addr=%0d, want valid=0 cnt=3 addr=3", valid_a, cnt_a, addr_a);
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b1 || instr_a !== mem(5'd3) || cnt_a !== 16'd4) begin
            errors++;
            $display("FAIL stall_release: valid=%b instr=%h cnt=%0d, want valid=1 instr=%h cnt=4",
                     valid_a, instr_a, cnt_a, mem(5'd3));
        end
    endtask

    task automatic test_branch;
        int n;
        wait_a(n);
        checks++;
        if (instr_a !== mem(5'd4)) begin
            errors++;
            $display("FAIL branch_pre: instr=%h, want %h", instr_a, mem(5'd4));
        end
        branch_target = 5'd17;
        branch_valid = 1'b1;
        wait_a(n);
        branch_valid = 1'b0;
        checks++;
        if (instr_a !== mem(5'd5) || addr_a !== 5'd17 || n !== 4) begin
            errors++;
            $display("FAIL branch_take: instr=%h addr=%0d gap=%0d, want instr=%h addr=17 gap=4",
                     instr_a, addr_a, n, mem(5'd5));
        end
        wait_a(n);
        checks++;
        if (instr_a !== mem(5'd17) || cnt_a !== 16'd7) begin
            errors++;
            $display("FAIL branch_t17: instr=%h cnt=%0d, want instr=%h cnt=7", instr_a, cnt_a, mem(5'd17));
        end
        wait_a(n);
        checks++;
        if (instr_a !== mem(5'd18) || addr_a !== 5'd19 || cnt_a !== 16'd8) begin
            errors++;
            $display("FAIL branch_t18: instr=%h addr=%0d cnt=%0d, want instr=%h addr=19 cnt=8",
                     instr_a, addr_a, cnt_a, mem(5'd18));
        end
    endtask

    task automatic test_halt;
        int n;
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 16'd8 || valid_a !== 1'b0 || addr_a !== 5'd19) begin
            errors++;
            $display("FAIL halt_done: done=%b busy=%b cnt=%0d valid=%b addr=%0d, want 1 0 8 0 19",
                     done_a, busy_a, cnt_a, valid_a, addr_a);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || valid_a !== 1'b0 || instr_a !== mem(5'd18)) begin
            errors++;
            $display("FAIL halt_hold: done=%b valid=%b instr=%h, want done=1 valid=0 instr=%h",
                     done_a, valid_a, instr_a, mem(5'd18));
        end
        pulse_start_a(5'd2);
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || cnt_a !== 16'd0 || addr_a !== 5'd2) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b cnt=%0d addr=%0d, want 1 0 0 2", busy_a, done_a, cnt_a, addr_a);
        end
        wait_a(n);
        checks++;
        if (n !== 4 || instr_a !== mem(5'd2) || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL restart_issue: gap=%0d instr=%h cnt=%0d, want gap=4 instr=%h cnt=1",
                     n, instr_a, cnt_a, mem(5'd2));
        end
        pulse_start_a(5'd20);
        wait_a(n);
        checks++;
        if (n !== 3 || instr_a !== mem(5'd3) || cnt_a !== 16'd2) begin
            errors++;
            $display("FAIL start_in_run: gap=%0d instr=%h cnt=%0d, want gap=3 instr=%h cnt=2",
                     n, instr_a, cnt_a, mem(5'd3));
        end
    endtask

    task automatic test_reset_run;
        logic bad;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({addr_a, instr_a, valid_a, busy_a, done_a, cnt_a} !== '0) begin
            errors++;
            $display("FAIL reset_run: addr=%0d instr=%h valid=%b busy=%b done=%b cnt=%0d, want all 0",
                     addr_a, instr_a, valid_a, busy_a, done_a, cnt_a);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || busy_a !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_idle: valid=%b busy=%b, want valid=0 busy=0", valid_a, busy_a);
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_wrap;
        test_stall;
        test_branch;
        test_halt;
        test_reset_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
